btle_tx_bit_scheduler: RTL and testbench
========================================

Name: btle_tx_bit_scheduler

Overview:
- Sequences the BLE TX bit datapath: fetches packet bytes from a synchronous-read byte buffer and serializes them LSB-first.
- Emits phy_bit/bit_valid/bit_valid_last at the 1M symbol rate (one pulse every CLK_PER_BIT clocks of the 16M clock).
- Directly drives the 1M-to-8M bit-repeat upsampler inputs, and owns packet start, busy and done signalling for the TX chain.

Parameters:
- CLK_PER_BIT, 16, clocks per output bit period; legal range >= 4.
- LEN_WIDTH, 9, width of the packet byte-count input.
- ADDR_WIDTH, 9, width of the buffer read address.

Ports:
- clk  input  1  system clock, 16M.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to transmit; sampled only in IDLE.
- pkt_len_byte  input  LEN_WIDTH  number of bytes to send; sampled with start.
- buf_addr  output  ADDR_WIDTH  registered byte-buffer read address.
- buf_data  input  8  buffer read data; valid the cycle after buf_addr changes (1-cycle latency).
- phy_bit  output  1  current serialized bit; held between pulses.
- bit_valid  output  1  one-cycle pulse per bit.
- bit_valid_last  output  1  one-cycle pulse coincident with the final bit_valid.
- busy  output  1  transmission in progress.
- done  output  1  one-cycle pulse on completion.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: all outputs 0, buf_addr 0, state IDLE, all counters 0. rst mid-packet aborts immediately. No bit_valid, bit_valid_last or done is produced for the aborted packet. The next start after reset is accepted normally.
- States:
  - IDLE -> FETCH0 on start with pkt_len_byte != 0.
  - FETCH0 -> LOAD0 after 1 cycle.
  - LOAD0 -> RUN after 1 cycle.
  - RUN -> DONE after the last bit.
  - DONE -> IDLE after 1 cycle.
- Start latency: start accepted at cycle T. buf_addr=0 at T+1 (busy=1 from T+1). Byte 0 latched at T+2. First bit_valid at T+3 with phy_bit=byte0[0].
- Bit timing: bit_valid pulses exactly every CLK_PER_BIT cycles, with no extra gap at byte boundaries. Bit order is LSB first within a byte; bytes go in address order 0..N-1.
- Prefetch: on the cycle bit 7 of byte k is emitted (k < N-1), buf_addr increments to k+1 on the next cycle. Data is captured into a next-byte register one cycle later. The shift register loads the next-byte register at the bit-0 emission of byte k+1.
- Last bit: the last bit (byte N-1, bit 7) asserts bit_valid and bit_valid_last in the same cycle L. done=1 and busy=0 at L+1. The block is back in IDLE at L+2; a start at L+2 or later is accepted.
- Total bit_valid pulses = 8*N, with L = T+3+(8N-1)*CLK_PER_BIT.
- start while busy, or in the DONE state: ignored, with no effect on the current packet.
- start with pkt_len_byte=0: no bits, busy stays 0. done pulses at T+1.
- buf_addr is not incremented past N-1; it holds its last value after completion until the next start resets it to 0.
- phy_bit holds its last value after the packet; it is meaningful only when bit_valid=1.
- Counters:
  - Period counter: ceil(log2(CLK_PER_BIT)) bits, wraps at CLK_PER_BIT-1.
  - Bit index: 3 bits, wraps 7->0.
  - Byte counter: LEN_WIDTH bits, compared against the latched N-1.

Test Plan:
- N=1, buffer[0]=8'hA5, start at T -> bit_valid at T+3, T+19, …, T+115. phy_bit sequence 1,0,1,0,0,1,0,1. bit_valid_last only at T+115. done at T+116.
- N=3, bytes 8'h01,8'h80,8'hFF -> 24 pulses exactly 16 cycles apart with no boundary gap. Bits 1,0000000, 0000000,1, 11111111. buf_addr steps 0,1,2. Final buf_addr=2.
- start pulsed repeatedly during an N=2 packet -> the packet is unaffected: 16 pulses, a single done, and no second packet.
- pkt_len_byte=0 with start -> no bit_valid, busy never asserted, done at T+1.
- rst asserted at cycle T+50 of an N=4 packet -> all outputs 0 next cycle with no done. A new start with N=1, byte 8'h3C gives its first bit_valid exactly 3 cycles after the start.
- CLK_PER_BIT=4 build, N=2, bytes 8'h55,8'hAA -> pulses every 4 cycles. Bits 1,0,1,0,1,0,1,0,0,1,0,1,0,1,0,1. bit_valid_last on pulse 16.

Source files
------------

// File: rtl/btle_tx_bit_scheduler.sv
// BLE TX bit scheduler: fetches packet bytes from a synchronous-read byte
// buffer and serializes them LSB-first at one bit per CLK_PER_BIT clocks.
// Drives phy_bit/bit_valid/bit_valid_last into the bit-repeat upsampler and
// provides busy/done signalling for the TX chain.
module btle_tx_bit_scheduler #(
  parameter int CLK_PER_BIT = 16,
  parameter int LEN_WIDTH   = 9,
  parameter int ADDR_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len_byte,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  input  logic [7:0]            buf_data,
  output logic                  phy_bit,
  output logic                  bit_valid,
  output logic                  bit_valid_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    LOAD0  = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     period_cnt;
  logic [2:0]           bit_idx;      // index of the bit currently on phy_bit
  logic [LEN_WIDTH-1:0] byte_cnt;     // index of the byte currently being sent
  logic [LEN_WIDTH-1:0] last_byte;    // latched N-1
  logic [7:0]           shift_reg;    // remaining bits of the current byte
  logic [7:0]           next_byte;    // prefetched following byte
  logic                 fetch_d1;     // buf_addr was just advanced
  logic                 fetch_d2;     // buf_data now holds the prefetched byte

  logic period_end;
  logic emit_last;
  logic prefetch_now;

  // Decode of the per-cycle scheduling conditions
  always_comb begin
    period_end   = (period_cnt == CNT_MAX);
    emit_last    = (bit_idx == 3'd6) && (byte_cnt == last_byte);
    prefetch_now = bit_valid && (bit_idx == 3'd7) && (byte_cnt != last_byte);
  end

  // Packet FSM, bit timing, prefetch pipeline and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      period_cnt     <= '0;
      bit_idx        <= '0;
      byte_cnt       <= '0;
      last_byte      <= '0;
      shift_reg      <= '0;
      next_byte      <= '0;
      fetch_d1       <= 1'b0;
      fetch_d2       <= 1'b0;
      buf_addr       <= '0;
      phy_bit        <= 1'b0;
      bit_valid      <= 1'b0;
      bit_valid_last <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      bit_valid      <= 1'b0;
      bit_valid_last <= 1'b0;
      done           <= 1'b0;
      fetch_d1       <= 1'b0;
      fetch_d2       <= fetch_d1;
      if (fetch_d2) begin
        next_byte <= buf_data;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            if (pkt_len_byte != '0) begin
              state      <= FETCH0;
              busy       <= 1'b1;
              buf_addr   <= '0;
              last_byte  <= pkt_len_byte - LEN_WIDTH'(1);
              byte_cnt   <= '0;
              bit_idx    <= '0;
              period_cnt <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end

        FETCH0: begin
          state <= LOAD0;
        end

        // Byte 0 arrives straight from the buffer, bypassing next_byte,
        // so the first bit goes out without waiting for the prefetch path.
        LOAD0: begin
          state      <= RUN;
          phy_bit    <= buf_data[0];
          shift_reg  <= {1'b0, buf_data[7:1]};
          bit_valid  <= 1'b1;
          bit_idx    <= '0;
          byte_cnt   <= '0;
          period_cnt <= '0;
        end

        RUN: begin
          if (bit_valid_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            if (prefetch_now) begin
              buf_addr <= buf_addr + ADDR_WIDTH'(1);
              fetch_d1 <= 1'b1;
            end
            if (period_end) begin
              period_cnt     <= '0;
              bit_valid      <= 1'b1;
              bit_valid_last <= emit_last;
              bit_idx        <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                phy_bit   <= next_byte[0];
                shift_reg <= {1'b0, next_byte[7:1]};
                byte_cnt  <= byte_cnt + LEN_WIDTH'(1);
              end else begin
                phy_bit   <= shift_reg[0];
                shift_reg <= {1'b0, shift_reg[7:1]};
              end
            end else begin
              period_cnt <= period_cnt + CNT_W'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btle_tx_bit_scheduler.sv
// Directed self-checking bench for btle_tx_bit_scheduler (16-clock and
// 4-clock bit period builds).
module tb_btle_tx_bit_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] pkt_len = '0;
  logic [8:0] buf_addr;
  logic [7:0] buf_data;
  logic       phy_bit, bit_valid, bit_valid_last, busy, done;

  logic       start4 = 1'b0;
  logic [8:0] pkt_len4 = '0;
  logic [8:0] buf_addr4;
  logic [7:0] buf_data4;
  logic       phy_bit4, bit_valid4, bit_valid_last4, busy4, done4;

  logic [7:0] mem [0:511];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int pulse_q[$];
  bit bits_q[$];
  int addr_q[$];
  int last_q[$];
  int done_q[$];
  bit busy_seen;
  bit busy_at_done;

  int p4_q[$];
  bit b4_q[$];
  int l4_q[$];
  int d4_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read byte buffers, one-cycle latency
  always @(posedge clk) begin
    buf_data  <= mem[buf_addr];
    buf_data4 <= mem[buf_addr4];
  end

  btle_tx_bit_scheduler #(.CLK_PER_BIT(16), .LEN_WIDTH(9), .ADDR_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_len_byte(pkt_len),
    .buf_addr(buf_addr), .buf_data(buf_data), .phy_bit(phy_bit),
    .bit_valid(bit_valid), .bit_valid_last(bit_valid_last),
    .busy(busy), .done(done)
  );

  btle_tx_bit_scheduler #(.CLK_PER_BIT(4), .LEN_WIDTH(9), .ADDR_WIDTH(9)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .pkt_len_byte(pkt_len4),
    .buf_addr(buf_addr4), .buf_data(buf_data4), .phy_bit(phy_bit4),
    .bit_valid(bit_valid4), .bit_valid_last(bit_valid_last4),
    .busy(busy4), .done(done4)
  );

  // Event recorders, sampled on the falling edge
  always @(negedge clk) begin
    if (bit_valid) begin
      pulse_q.push_back(cyc);
      bits_q.push_back(phy_bit);
      addr_q.push_back(int'(buf_addr));
    end
    if (bit_valid_last) last_q.push_back(cyc);
    if (done) begin
      done_q.push_back(cyc);
      busy_at_done = busy;
    end
    if (busy) busy_seen = 1'b1;
    if (bit_valid4) begin
      p4_q.push_back(cyc);
      b4_q.push_back(phy_bit4);
    end
    if (bit_valid_last4) l4_q.push_back(cyc);
    if (done4) d4_q.push_back(cyc);
  end

  task automatic clear_logs();
    pulse_q.delete(); bits_q.delete(); addr_q.delete();
    last_q.delete(); done_q.delete(); busy_seen = 1'b0; busy_at_done = 1'b1;
    p4_q.delete(); b4_q.delete(); l4_q.delete(); d4_q.delete();
  endtask

  task automatic pulse_start(input logic [8:0] n, output int t);
    @(posedge clk); #1;
    pkt_len = n; start = 1'b1; t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_q.size() != 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    checks++;
    if ({phy_bit, bit_valid, bit_valid_last, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {phy_bit, bit_valid, bit_valid_last, busy, done});
    end
    checks++;
    if (buf_addr !== 9'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d expected 0", buf_addr);
    end
    rst = 1'b0;
    wait_cycles(2);
    checks++;
    if (busy !== 1'b0 || bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b bit_valid=%b expected 0 0", busy, bit_valid);
    end
  endtask

  task automatic test_single_byte();
    int t0;
    logic [63:0] got;
    clear_logs();
    mem[0] = 8'hA5;
    pulse_start(9'd1, t0);
    checks++;
    if (busy !== 1'b1 || buf_addr !== 9'd0) begin
      errors++;
      $display("FAIL start_latency: busy=%b addr=%0d expected 1 0", busy, buf_addr);
    end
    wait_done(300);
    wait_cycles(3);
    checks++;
    if (pulse_q.size() !== 8) begin
      errors++;
      $display("FAIL n1_pulse_count: got %0d expected 8", pulse_q.size());
    end
    for (int i = 0; i < pulse_q.size(); i++) begin
      checks++;
      if (pulse_q[i] !== t0 + 3 + i * 16) begin
        errors++;
        $display("FAIL n1_pulse_time[%0d]: got T+%0d expected T+%0d", i, pulse_q[i] - t0, 3 + i * 16);
      end
    end
    got = '0;
    foreach (bits_q[i]) got[i] = bits_q[i];
    checks++;
    if (got !== 64'h00000000000000A5) begin
      errors++;
      $display("FAIL n1_bits: got %h expected a5", got);
    end
    checks++;
    if (last_q.size() !== 1 || (last_q.size() == 1 && last_q[0] !== t0 + 115)) begin
      errors++;
      $display("FAIL n1_last: count=%0d first=T+%0d expected 1 at T+115", last_q.size(),
               (last_q.size() != 0) ? last_q[0] - t0 : -1);
    end
    checks++;
    if (done_q.size() !== 1 || (done_q.size() == 1 && done_q[0] !== t0 + 116)) begin
      errors++;
      $display("FAIL n1_done: count=%0d first=T+%0d expected 1 at T+116", done_q.size(),
               (done_q.size() != 0) ? done_q[0] - t0 : -1);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL n1_busy_at_done: got %b expected 0", busy_at_done);
    end
  endtask

  task automatic test_multi_byte();
    int t0;
    logic [63:0] got;
    clear_logs();
    mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hFF;
    pulse_start(9'd3, t0);
    wait_done(600);
    wait_cycles(3);
    checks++;
    if (pulse_q.size() !== 24) begin
      errors++;
      $display("FAIL n3_pulse_count: got %0d expected 24", pulse_q.size());
    end
    for (int i = 0; i < pulse_q.size(); i++) begin
      checks++;
      if (pulse_q[i] !== t0 + 3 + i * 16) begin
        errors++;
        $display("FAIL n3_pulse_time[%0d]: got T+%0d expected T+%0d", i, pulse_q[i] - t0, 3 + i * 16);
      end
      checks++;
      if (addr_q[i] !== i / 8) begin
        errors++;
        $display("FAIL n3_addr_at_pulse[%0d]: got %0d expected %0d", i, addr_q[i], i / 8);
      end
    end
    got = '0;
    foreach (bits_q[i]) got[i] = bits_q[i];
    checks++;
    if (got !== 64'h0000000000FF8001) begin
      errors++;
      $display("FAIL n3_bits: got %h expected ff8001", got);
    end
    checks++;
    if (buf_addr !== 9'd2) begin
      errors++;
      $display("FAIL n3_final_addr: got %0d expected 2", buf_addr);
    end
    checks++;
    if (last_q.size() !== 1 || (last_q.size() == 1 && last_q[0] !== t0 + 3 + 23 * 16)) begin
      errors++;
      $display("FAIL n3_last: count=%0d expected 1 at T+%0d", last_q.size(), 3 + 23 * 16);
    end
  endtask

  task automatic test_start_while_busy();
    int t0, c;
    logic [63:0] got;
    clear_logs();
    mem[0] = 8'h3C; mem[1] = 8'hC3;
    pulse_start(9'd2, t0);
    // Extra starts every 7 cycles while busy, plus one in the DONE cycle
    forever begin
      @(posedge clk); #1;
      c = cyc - t0;
      if (c > 244) begin
        start = 1'b0;
        break;
      end
      pkt_len = 9'd5;
      start = ((c % 7) == 0) || (c == 244);
    end
    wait_cycles(80);
    checks++;
    if (pulse_q.size() !== 16) begin
      errors++;
      $display("FAIL busy_start_pulses: got %0d expected 16", pulse_q.size());
    end
    got = '0;
    foreach (bits_q[i]) got[i] = bits_q[i];
    checks++;
    if (got !== 64'h000000000000C33C) begin
      errors++;
      $display("FAIL busy_start_bits: got %h expected c33c", got);
    end
    checks++;
    if (done_q.size() !== 1 || (done_q.size() == 1 && done_q[0] !== t0 + 244)) begin
      errors++;
      $display("FAIL busy_start_done: count=%0d expected 1 at T+244", done_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_zero_length();
    int t0;
    clear_logs();
    pulse_start(9'd0, t0);
    wait_cycles(20);
    checks++;
    if (done_q.size() !== 1 || (done_q.size() == 1 && done_q[0] !== t0 + 1)) begin
      errors++;
      $display("FAIL zero_len_done: count=%0d expected 1 at T+1", done_q.size());
    end
    checks++;
    if (pulse_q.size() !== 0) begin
      errors++;
      $display("FAIL zero_len_pulses: got %0d expected 0", pulse_q.size());
    end
    checks++;
    if (busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_busy: got %b expected 0", busy_seen);
    end
  endtask

  task automatic test_reset_abort();
    int t0, t1;
    logic [63:0] got;
    clear_logs();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    pulse_start(9'd4, t0);
    while (cyc < t0 + 50) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({phy_bit, bit_valid, bit_valid_last, busy, done} !== 5'b0 || buf_addr !== 9'd0) begin
      errors++;
      $display("FAIL abort_outputs: got %b addr=%0d expected 00000 addr=0",
               {phy_bit, bit_valid, bit_valid_last, busy, done}, buf_addr);
    end
    rst = 1'b0;
    wait_cycles(60);
    checks++;
    if (pulse_q.size() !== 3 || done_q.size() !== 0 || last_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_no_tail: pulses=%0d done=%0d last=%0d expected 3 0 0",
               pulse_q.size(), done_q.size(), last_q.size());
    end
    clear_logs();
    mem[0] = 8'h3C;
    pulse_start(9'd1, t1);
    wait_done(300);
    wait_cycles(3);
    checks++;
    if (pulse_q.size() !== 8 || (pulse_q.size() != 0 && pulse_q[0] !== t1 + 3)) begin
      errors++;
      $display("FAIL restart_first_pulse: count=%0d first=T+%0d expected 8 at T+3", pulse_q.size(),
               (pulse_q.size() != 0) ? pulse_q[0] - t1 : -1);
    end
    got = '0;
    foreach (bits_q[i]) got[i] = bits_q[i];
    checks++;
    if (got !== 64'h000000000000003C) begin
      errors++;
      $display("FAIL restart_bits: got %h expected 3c", got);
    end
    checks++;
    if (done_q.size() !== 1 || (done_q.size() == 1 && done_q[0] !== t1 + 116)) begin
      errors++;
      $display("FAIL restart_done: count=%0d expected 1 at T+116", done_q.size());
    end
  endtask

  task automatic test_cpb4();
    int t0;
    logic [63:0] got;
    clear_logs();
    mem[0] = 8'h55; mem[1] = 8'hAA;
    @(posedge clk); #1;
    pkt_len4 = 9'd2; start4 = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (d4_q.size() != 0) break;
      @(posedge clk); #1;
    end
    wait_cycles(3);
    checks++;
    if (p4_q.size() !== 16) begin
      errors++;
      $display("FAIL cpb4_pulse_count: got %0d expected 16", p4_q.size());
    end
    for (int i = 0; i < p4_q.size(); i++) begin
      checks++;
      if (p4_q[i] !== t0 + 3 + i * 4) begin
        errors++;
        $display("FAIL cpb4_pulse_time[%0d]: got T+%0d expected T+%0d", i, p4_q[i] - t0, 3 + i * 4);
      end
    end
    got = '0;
    foreach (b4_q[i]) got[i] = b4_q[i];
    checks++;
    if (got !== 64'h000000000000AA55) begin
      errors++;
      $display("FAIL cpb4_bits: got %h expected aa55", got);
    end
    checks++;
    if (l4_q.size() !== 1 || (l4_q.size() == 1 && l4_q[0] !== t0 + 63)) begin
      errors++;
      $display("FAIL cpb4_last: count=%0d expected 1 at T+63", l4_q.size());
    end
    checks++;
    if (d4_q.size() !== 1 || (d4_q.size() == 1 && d4_q[0] !== t0 + 64)) begin
      errors++;
      $display("FAIL cpb4_done: count=%0d expected 1 at T+64", d4_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    clear_logs();
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_start_while_busy();
    test_zero_length();
    test_reset_abort();
    test_cpb4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
